// File: rtl/local_port_if.sv
// Bundles the per-cycle channel bus, the local injection port and the local
// eject port of the router's local eject/inject stage. The upstream side
// (alloc stage plus local node) uses the master view; the stage uses slave.
interface local_port_if #(
  parameter int NUM_CHANNEL = 5,
  parameter int NUM_PORT    = 6,
  parameter int WIDTH_PORT  = 64
);
  logic [NUM_CHANNEL*WIDTH_PORT-1:0]  flit_i;
  logic [NUM_CHANNEL-1:0]             valid_i;
  logic [NUM_CHANNEL*NUM_PORT-1:0]    alloc_i;
  logic                               inj_valid_i;
  logic                               inj_ready_o;
  logic [WIDTH_PORT-1:0]              inj_flit_i;
  logic [NUM_CHANNEL-1:0]             inj_pv_i;
  logic                               ej_valid_o;
  logic                               ej_ready_i;
  logic [WIDTH_PORT-1:0]              ej_flit_o;
  logic [NUM_CHANNEL*WIDTH_PORT-1:0]  xbar_flit_o;
  logic [NUM_CHANNEL-1:0]             xbar_valid_o;
  logic [NUM_CHANNEL*NUM_CHANNEL-1:0] xbar_pv_o;
  logic                               starve_o;

  modport master (
    output flit_i, valid_i, alloc_i, inj_valid_i, inj_flit_i, inj_pv_i, ej_ready_i,
    input  inj_ready_o, ej_valid_o, ej_flit_o, xbar_flit_o, xbar_valid_o, xbar_pv_o, starve_o
  );

  modport slave (
    input  flit_i, valid_i, alloc_i, inj_valid_i, inj_flit_i, inj_pv_i, ej_ready_i,
    output inj_ready_o, ej_valid_o, ej_flit_o, xbar_flit_o, xbar_valid_o, xbar_pv_o, starve_o
  );
endinterface

// File: rtl/local_port_stage.sv
// Registered local eject/inject stage of the bufferless router. Ejects up to
// EJ_WIDTH local flits per cycle into the eject FIFO, deflects the local flits
// that do not fit onto the lowest unused non-local ports, and injects the head
// of the injection FIFO into the lowest free channel. All crossbar-facing
// results are registered, so the stage costs one cycle. FIFO depths must be
// powers of two and at least 2.
module local_port_stage #(
  parameter int NUM_CHANNEL  = 5,
  parameter int NUM_PORT     = 6,
  parameter int WIDTH_PORT   = 64,
  parameter int EJ_WIDTH     = 1,
  parameter int EJ_DEPTH     = 4,
  parameter int INJ_DEPTH    = 4,
  parameter int STARVE_LIMIT = 8
) (
  input logic        clk,
  input logic        rst_n,
  local_port_if.slave bus
);
  localparam int NC  = NUM_CHANNEL;
  localparam int W   = WIDTH_PORT;
  localparam int LOC = NUM_PORT - 2;
  localparam int EW  = $clog2(EJ_DEPTH + 1);
  localparam int EIW = $clog2(EJ_DEPTH);
  localparam int IW  = $clog2(INJ_DEPTH + 1);
  localparam int IIW = $clog2(INJ_DEPTH);
  localparam int BW  = $clog2(STARVE_LIMIT + 1);

  // Drop the local alloc bit, keeping the remaining bits in order.
  function automatic logic [NC-1:0] repack(input logic [NUM_PORT-1:0] a);
    logic [NC-1:0] r;
    for (int p = 0; p < NC; p++) r[p] = (p < LOC) ? a[p] : a[p+1];
    return r;
  endfunction

  function automatic logic [NC-1:0] lowestOne(input logic [NC-1:0] v);
    return v & (~v + NC'(1));
  endfunction

  function automatic logic [BW-1:0] satInc(input logic [BW-1:0] x);
    return (x == BW'(STARVE_LIMIT)) ? x : x + BW'(1);
  endfunction

  logic [W-1:0]    ejMem [EJ_DEPTH];
  logic [EIW-1:0]  ejWr, ejRd;
  logic [EW-1:0]   ejCount;
  logic [W-1:0]    injFlitMem [INJ_DEPTH];
  logic [NC-1:0]   injPvMem [INJ_DEPTH];
  logic [IIW-1:0]  injWr, injRd;
  logic [IW-1:0]   injCount;
  logic [BW-1:0]   blkCnt, blkNext;
  logic            starveQ;
  logic [NC*W-1:0]  xFlitQ, xFlitNext;
  logic [NC-1:0]    xValidQ, outValid;
  logic [NC*NC-1:0] xPvQ, xPvNext;

  logic [NC-1:0] localSet, ejMask, taken, freeCh, injChOh, injCand, injPortOh, pvIn;
  logic [EW-1:0] ejOrd [NC];
  logic [EW-1:0] ejN, ejSpace;
  logic          doInj, injPush, ejPop, injReady, found;

  assign injReady        = (injCount != IW'(INJ_DEPTH));
  assign injPush         = bus.inj_valid_i & injReady;
  assign ejPop           = (ejCount != '0) & bus.ej_ready_i;
  assign bus.inj_ready_o = injReady;
  assign bus.ej_valid_o  = (ejCount != '0);
  assign bus.ej_flit_o   = (ejCount != '0) ? ejMem[ejRd] : '0;
  assign bus.xbar_flit_o  = xFlitQ;
  assign bus.xbar_valid_o = xValidQ;
  assign bus.xbar_pv_o    = xPvQ;
  assign bus.starve_o     = starveQ;

  // Eject, deflect and inject decisions for the current channel set.
  always_comb begin
    taken     = '0;
    localSet  = '0;
    ejMask    = '0;
    ejN       = '0;
    outValid  = '0;
    xFlitNext = '0;
    xPvNext   = '0;
    pvIn      = '0;
    found     = 1'b0;
    ejSpace   = EW'(EJ_DEPTH) - ejCount;
    for (int c = 0; c < NC; c++) begin
      ejOrd[c] = '0;
      pvIn = repack(bus.alloc_i[c*NUM_PORT +: NUM_PORT]);
      if (bus.valid_i[c]) begin
        if (bus.alloc_i[c*NUM_PORT + LOC]) begin
          localSet[c] = 1'b1;
        end else begin
          taken                = taken | pvIn;
          outValid[c]          = 1'b1;
          xFlitNext[c*W +: W]  = bus.flit_i[c*W +: W];
          xPvNext[c*NC +: NC]  = pvIn;
        end
      end
    end
    for (int c = 0; c < NC; c++) begin
      if (localSet[c] && (ejN < EW'(EJ_WIDTH)) && (ejN < ejSpace)) begin
        ejMask[c] = 1'b1;
        ejOrd[c]  = ejN;
        ejN       = ejN + EW'(1);
      end
    end
    for (int c = 0; c < NC; c++) begin
      if (localSet[c] && !ejMask[c]) begin
        found = 1'b0;
        for (int p = 0; p < NC; p++) begin
          if (!found && !taken[p]) begin
            taken[p]          = 1'b1;
            xPvNext[c*NC + p] = 1'b1;
            found             = 1'b1;
          end
        end
        outValid[c]         = 1'b1;
        xFlitNext[c*W +: W] = bus.flit_i[c*W +: W];
      end
    end
    freeCh    = ~outValid;
    doInj     = (injCount != '0) && (|freeCh);
    injChOh   = lowestOne(freeCh);
    injCand   = injPvMem[injRd] & ~taken;
    injPortOh = (|injCand) ? lowestOne(injCand) : lowestOne(~taken);
    if (doInj) begin
      for (int c = 0; c < NC; c++) begin
        if (injChOh[c]) begin
          outValid[c]         = 1'b1;
          xFlitNext[c*W +: W] = injFlitMem[injRd];
          xPvNext[c*NC +: NC] = injPortOh;
        end
      end
    end
    blkNext = ((injCount == '0) || doInj) ? '0 : satInc(blkCnt);
  end

  // Stage boundary: control state, pointers and registered crossbar outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ejWr     <= '0;
      ejRd     <= '0;
      ejCount  <= '0;
      injWr    <= '0;
      injRd    <= '0;
      injCount <= '0;
      blkCnt   <= '0;
      starveQ  <= 1'b0;
      xFlitQ   <= '0;
      xValidQ  <= '0;
      xPvQ     <= '0;
    end else begin
      ejWr     <= ejWr + EIW'(ejN);
      ejRd     <= ejRd + EIW'(ejPop);
      ejCount  <= ejCount + ejN - EW'(ejPop);
      injWr    <= injWr + IIW'(injPush);
      injRd    <= injRd + IIW'(doInj);
      injCount <= injCount + IW'(injPush) - IW'(doInj);
      blkCnt   <= blkNext;
      starveQ  <= (blkNext == BW'(STARVE_LIMIT));
      xFlitQ   <= xFlitNext;
      xValidQ  <= outValid;
      xPvQ     <= xPvNext;
    end
  end

  // FIFO storage writes; contents are qualified by the counts, so no reset.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NC; c++) begin
      if (ejMask[c]) ejMem[ejWr + EIW'(ejOrd[c])] <= bus.flit_i[c*W +: W];
    end
    if (injPush) begin
      injFlitMem[injWr] <= bus.inj_flit_i;
      injPvMem[injWr]   <= bus.inj_pv_i;
    end
  end

  // Every flit still on a channel holds a distinct port, so a free channel
  // always leaves a free port for the injected flit.
  assert property (@(posedge clk) disable iff (!rst_n) doInj |-> (|(~taken)));
endmodule
